// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - collapsing-queue reservation station for the integer ALU issue port
// Optional checks compiled in with ALU_RS_ASSERT_EN.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [3:0]                 disp_ctrl,
  input  logic                       disp_alusrc,
  input  logic [31:0]                disp_imm,
  input  logic [TAG_W-1:0]           disp_dst_tag,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic [TAG_W-1:0]           disp_src1_tag,
  input  logic [TAG_W-1:0]           disp_src2_tag,
  input  logic [31:0]                disp_src1_val,
  input  logic [31:0]                disp_src2_val,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_data,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [31:0]                issue_rs1,
  output logic [31:0]                issue_rs2,
  output logic [31:0]                issue_imm,
  output logic                       issue_alusrc,
  output logic [3:0]                 issue_ctrl,
  output logic [TAG_W-1:0]           issue_dst_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [3:0]       ctrl;
    logic             alusrc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dst;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_val;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [31:0]      s2_val;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             ent_ext [DEPTH+1];
  logic [OCC_W-1:0] occ_q, occ_d;

  ent_t sel_ent;
  ent_t new_ent;
  ent_t shifted;
  logic any_rdy;
  logic fire;
  logic disp_acc;
  int   sel_i;
  int   tail_i;

  function automatic ent_t wake(input ent_t e, input logic cv,
                                input logic [TAG_W-1:0] ct, input logic [31:0] cd);
    ent_t r;
    r = e;
    if (cv && r.valid) begin
      if (!r.s1_rdy && r.s1_tag == ct) begin
        r.s1_rdy = 1'b1;
        r.s1_val = cd;
      end
      if (!r.s2_rdy && r.s2_tag == ct) begin
        r.s2_rdy = 1'b1;
        r.s2_val = cd;
      end
    end
    return r;
  endfunction

  assign disp_ready = (occ_q < DEPTH_C);
  assign occupancy  = occ_q;

  // Oldest ready entry wins; scan from the top so the lowest index is kept.
  always_comb begin
    sel_ent = '0;
    sel_i   = 0;
    any_rdy = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].s1_rdy && (ent_q[i].s2_rdy || ent_q[i].alusrc)) begin
        sel_ent = ent_q[i];
        sel_i   = i;
        any_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    issue_valid   = any_rdy && !flush;
    issue_rs1     = sel_ent.s1_val;
    issue_rs2     = sel_ent.s2_val;
    issue_imm     = sel_ent.imm;
    issue_alusrc  = sel_ent.alusrc;
    issue_ctrl    = sel_ent.ctrl;
    issue_dst_tag = sel_ent.dst;
  end

  always_comb begin
    fire     = issue_valid && issue_ready;
    disp_acc = disp_valid && disp_ready && !flush;
    tail_i   = int'(occ_q) - (fire ? 1 : 0);

    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.ctrl   = disp_ctrl;
    new_ent.alusrc = disp_alusrc;
    new_ent.imm    = disp_imm;
    new_ent.dst    = disp_dst_tag;
    new_ent.s1_rdy = disp_src1_rdy;
    new_ent.s1_tag = disp_src1_tag;
    new_ent.s1_val = disp_src1_rdy ? disp_src1_val : 32'd0;
    new_ent.s2_rdy = disp_src2_rdy;
    new_ent.s2_tag = disp_src2_tag;
    new_ent.s2_val = disp_src2_rdy ? disp_src2_val : 32'd0;
    new_ent        = wake(new_ent, cdb_valid, cdb_tag, cdb_data);

    for (int i = 0; i < DEPTH; i++) ent_ext[i] = ent_q[i];
    ent_ext[DEPTH] = '0;

    shifted = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shifted  = (fire && i >= sel_i) ? ent_ext[i+1] : ent_ext[i];
      ent_d[i] = wake(shifted, cdb_valid, cdb_tag, cdb_data);
      if (disp_acc && i == tail_i) ent_d[i] = new_ent;
      if (flush) ent_d[i] = '0;
    end

    occ_d = occ_q - OCC_W'(fire) + OCC_W'(disp_acc);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

`ifdef ALU_RS_ASSERT_EN
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= DEPTH_C);
  a_no_overflow_disp: assert property (@(posedge clk) disable iff (!rst_n)
    disp_valid |-> disp_ready);
  a_issue_ready: assert property (@(posedge clk) disable iff (!rst_n)
    issue_valid |-> (sel_ent.valid && sel_ent.s1_rdy && (sel_ent.s2_rdy || sel_ent.alusrc)));
  a_legal_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
    issue_valid |-> (issue_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1110}));
  for (genvar g = 0; g < DEPTH; g++) begin : g_contig
    a_contig: assert property (@(posedge clk) disable iff (!rst_n)
      ent_q[g].valid == (g < int'(occ_q)));
  end
`else
`endif

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed scoreboard bench for alu_rs
module tb_alu_rs;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_ctrl;
  logic             disp_alusrc;
  logic [31:0]      disp_imm;
  logic [TAG_W-1:0] disp_dst_tag;
  logic             disp_src1_rdy, disp_src2_rdy;
  logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag;
  logic [31:0]      disp_src1_val, disp_src2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_ready;
  logic             issue_valid;
  logic [31:0]      issue_rs1, issue_rs2, issue_imm;
  logic             issue_alusrc;
  logic [3:0]       issue_ctrl;
  logic [TAG_W-1:0] issue_dst_tag;
  logic [3:0]       occupancy;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
    .disp_alusrc(disp_alusrc), .disp_imm(disp_imm), .disp_dst_tag(disp_dst_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm),
    .issue_alusrc(issue_alusrc), .issue_ctrl(issue_ctrl),
    .issue_dst_tag(issue_dst_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       ctrl;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
    logic             alusrc;
    logic [TAG_W-1:0] dst;
  } exp_t;

  exp_t sb[$];
  int   n_eval = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] ctrl, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic alusrc, input logic [TAG_W-1:0] dst);
    exp_t e;
    e.ctrl = ctrl; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alusrc = alusrc; e.dst = dst;
    sb.push_back(e);
  endtask

  task automatic disp(input logic [3:0] ctrl, input logic [TAG_W-1:0] dst,
                      input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                      input logic alusrc, input logic [31:0] imm);
    disp_valid = 1'b1; disp_ctrl = ctrl; disp_dst_tag = dst;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_alusrc = alusrc; disp_imm = imm;
  endtask

  // Every handshake observed must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue_dst", {26'd0, issue_dst_tag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_dst", {26'd0, issue_dst_tag}, {26'd0, e.dst});
        chk("issue_ctrl", {28'd0, issue_ctrl}, {28'd0, e.ctrl});
        chk("issue_rs1", issue_rs1, e.rs1);
        chk("issue_alusrc", {31'd0, issue_alusrc}, {31'd0, e.alusrc});
        if (e.alusrc) chk("issue_imm", issue_imm, e.imm);
        else          chk("issue_rs2", issue_rs2, e.rs2);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_ctrl = '0; disp_alusrc = 1'b0;
    disp_imm = '0; disp_dst_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_val = '0; disp_src2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    tick; tick;
    chk("rst_occupancy", {28'd0, occupancy}, 32'd0);
    chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_issue_rs1", issue_rs1, 32'd0);
    chk("rst_issue_ctrl", {28'd0, issue_ctrl}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Ready add issues the cycle after dispatch.
    issue_ready = 1'b1;
    disp(4'b0010, 6'd1, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 1'b0, 32'd0);
    chk("t1_no_same_cycle_issue", {31'd0, issue_valid}, 32'd0);
    push(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 6'd1);
    tick;
    disp_valid = 1'b0;
    chk("t1_occ1", {28'd0, occupancy}, 32'd1);
    chk("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
    tick;
    chk("t1_occ0", {28'd0, occupancy}, 32'd0);
    chk("t1_idle", {31'd0, issue_valid}, 32'd0);

    // Older sub waits on tag 3; younger ready xor overtakes it.
    disp(4'b0110, 6'd10, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd2, 1'b0, 32'd0);
    tick;
    disp(4'b0011, 6'd11, 1'b1, 6'd0, 32'h0A, 1'b1, 6'd0, 32'h05, 1'b0, 32'd0);
    push(4'b0011, 32'h0A, 32'h05, 32'd0, 1'b0, 6'd11);
    tick;
    disp_valid = 1'b0;
    chk("t2_xor_valid", {31'd0, issue_valid}, 32'd1);
    tick;
    chk("t2_sub_waiting", {31'd0, issue_valid}, 32'd0);
    chk("t2_occ1", {28'd0, occupancy}, 32'd1);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h10;
    push(4'b0110, 32'h10, 32'd2, 32'd0, 1'b0, 6'd10);
    tick;
    cdb_valid = 1'b0;
    chk("t2_sub_woken", {31'd0, issue_valid}, 32'd1);
    tick;
    chk("t2_occ0", {28'd0, occupancy}, 32'd0);

    // Dispatch-time CDB bypass.
    disp(4'b0001, 6'd13, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 1'b0, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hFFFF_FFF0;
    push(4'b0001, 32'hFFFF_FFF0, 32'd1, 32'd0, 1'b0, 6'd13);
    tick;
    disp_valid = 1'b0; cdb_valid = 1'b0;
    chk("t3_bypass_valid", {31'd0, issue_valid}, 32'd1);
    tick;

    // Fill, reject overflow, drain in order.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'b0010, 6'(20 + i), 1'b1, 6'd0, 32'(i + 100), 1'b1, 6'd0, 32'(i * 3), 1'b0, 32'd0);
      push(4'b0010, 32'(i + 100), 32'(i * 3), 32'd0, 1'b0, 6'(20 + i));
      tick;
    end
    chk("t4_full_occ", {28'd0, occupancy}, 32'd8);
    chk("t4_full_not_ready", {31'd0, disp_ready}, 32'd0);
    disp(4'b0000, 6'd40, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 1'b0, 32'd0);
    tick;
    chk("t4_ninth_ignored", {28'd0, occupancy}, 32'd8);
    issue_ready = 1'b1;
    tick;
    disp_valid = 1'b0;
    chk("t4_issue_plus_disp_at_full", {28'd0, occupancy}, 32'd7);
    for (int k = 2; k <= DEPTH; k++) begin
      tick;
      chk("t4_drain_occ", {28'd0, occupancy}, 32'(DEPTH - k));
    end

    // Flush beats dispatch and issue.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'b0000, 6'(50 + i), 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 1'b0, 32'd0);
      tick;
    end
    chk("t5_occ4", {28'd0, occupancy}, 32'd4);
    disp(4'b0001, 6'd60, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 1'b0, 32'd0);
    flush = 1'b1; issue_ready = 1'b1;
    #1;
    chk("t5_issue_masked", {31'd0, issue_valid}, 32'd0);
    tick;
    flush = 1'b0; disp_valid = 1'b0;
    chk("t5_occ0", {28'd0, occupancy}, 32'd0);
    chk("t5_issue_valid", {31'd0, issue_valid}, 32'd0);

    // Immediate form never waits on src2.
    disp(4'b1110, 6'd14, 1'b1, 6'd0, 32'h8000_0000, 1'b0, 6'd12, 32'd0, 1'b1, 32'd4);
    push(4'b1110, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 6'd14);
    tick;
    disp_valid = 1'b0;
    chk("t6_imm_valid", {31'd0, issue_valid}, 32'd1);
    tick;
    chk("t6_occ0", {28'd0, occupancy}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU issue port. It buffers dispatched ALU ops until both source operands are available, and captures operand values broadcast on the common data bus (CDB). Each cycle it presents the oldest ready op to the ALU, whose registered output goes back onto the CDB. It sits between rename/dispatch and the ALU stage.

## Interface
- DEPTH, 8, number of entries (≥2)
- TAG_W, 6, physical-register / ROB tag width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  space available
- disp_ctrl  in  4  ALU_ctrl code (and=0000, or=0001, add=0010, xor=0011, sub=0110, sra=1110)
- disp_alusrc  in  1  1 = operand B is immediate
- disp_imm  in  32  immediate
- disp_dst_tag  in  TAG_W  result tag
- disp_src1_rdy / disp_src2_rdy  in  1  source value already valid
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when not ready
- disp_src1_val / disp_src2_val  in  32  value when ready
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  32  broadcast value
- issue_ready  in  1  ALU accepts an op this cycle
- issue_valid  out  1  op presented
- issue_rs1 / issue_rs2 / issue_imm  out  32  operand values
- issue_alusrc  out  1
- issue_ctrl  out  4
- issue_dst_tag  out  TAG_W
- occupancy  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Collapsing queue: entry 0 is oldest. Valid entries are always contiguous at 0..occupancy-1.
- An entry is ready when src1_rdy && (src2_rdy || alusrc). When alusrc=1, src2 is never waited on.
- Issue selection: the lowest-index ready entry. Its fields drive the issue_* outputs combinationally from registered state.
- Issue handshake: the selected entry is removed on an edge where issue_valid && issue_ready. Entries above it shift down by one.
- Dispatch: when disp_valid && disp_ready, the new entry is written at the tail. The tail is computed after any same-cycle removal.
- disp_ready = (occupancy < DEPTH). It is based on registered occupancy only and does not credit a same-cycle issue.
- disp_valid while disp_ready=0 is ignored.
- CDB wakeup: on cdb_valid, every valid entry whose non-ready source tag equals cdb_tag latches cdb_data and sets that rdy bit. This applies to entries being shifted in the same cycle.
- Dispatch bypass: if a dispatched source is not ready and its tag equals the same-cycle cdb_tag with cdb_valid, the entry is written with the source ready and the value set to cdb_data.
- One CDB match may wake both sources of an entry.
- Removed entries and non-ready source values are don't-care. Implementations zero them on removal.
- Flush: on the edge where flush=1, all entries are invalidated and occupancy becomes 0. Flush overrides dispatch and any issue in that cycle. issue_valid is forced to 0 while flush=1.
- Reset values: occupancy 0, all entries invalid, issue_valid 0, all issue_* fields 0, disp_ready 1.

## Timing
- Dispatch with both operands ready at edge t: issue_valid=1 in the cycle after t. There is no same-cycle dispatch-to-issue path.
- CDB wakeup at edge t: the entry is issue-eligible in the cycle after t.
- Back-to-back issue: one op per cycle while ready entries exist and issue_ready=1.
- Issue results leave the ALU one edge after the issue handshake (ALU output is registered). They return on the CDB per the writeback arbiter.
- Simultaneous issue and dispatch when occupancy = DEPTH: the dispatch is rejected, because disp_ready=0.
- rst_n assertion mid-operation clears all state immediately (asynchronous). Deassertion is synchronized externally.

## Configuration
- ALU_RS_ASSERT_EN defined: concurrent assertions are compiled in, clocked on posedge clk and disabled while !rst_n. They check:
  - occupancy ≤ DEPTH;
  - no disp_valid while disp_ready=0;
  - issue_valid implies the selected entry is ready;
  - entries 0..occupancy-1 are valid and all others invalid;
  - issue_ctrl is one of the six legal codes when issue_valid.
- ALU_RS_ASSERT_EN undefined: no assertions. Functional behaviour is identical.

## Test plan
- Reset, then dispatch add with src1_val=5, src2_val=7, both ready, issue_ready=1 → next cycle issue_valid=1, issue_ctrl=0010, rs1=5, rs2=7; occupancy returns 1→0.
- Dispatch sub waiting on tag 3 (entry 0), then xor fully ready (entry 1) → the xor issues first. Then cdb_valid, tag=3, data=0x10 → sub issues the next cycle with rs1=0x10.
- Dispatch with src1 tag 9 in the same cycle as cdb_valid, tag=9, data=0xFFFF_FFF0 → entry is ready at dispatch and issues with rs1=0xFFFF_FFF0.
- With issue_ready=0, fill DEPTH=8 entries → disp_ready=0, and a 9th disp_valid is ignored. Raise issue_ready → 8 issues in consecutive cycles, in order, with occupancy 8→0.
- With 4 entries queued, assert flush together with disp_valid and issue_ready → occupancy=0, issue_valid=0 the next cycle, and nothing issued.
- Dispatch sra with alusrc=1, imm=4, src2_rdy=0 (tag 12) → it issues without any CDB broadcast, with issue_alusrc=1 and issue_imm=4.
